// File: rtl/frame_seq_pkg.sv
// Shared state encoding and default sizing for the frame sequencer.
package frame_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WAIT,
    S_PUSH,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam int unsigned PIX_W_DEF  = 8;
  localparam int unsigned N_PIX_DEF  = 76800;
  localparam int unsigned ADDR_W_DEF = 17;
  localparam int unsigned WDOG_CYC   = 16_000_000;
  localparam int unsigned WDOG_W     = 24;

  function automatic logic is_busy(input state_t s);
    return (s == S_RD) || (s == S_WAIT) || (s == S_PUSH) || (s == S_DRAIN);
  endfunction

endpackage

// File: rtl/frame_seq_capture.sv
// Destination-side capture: write counter, registered RAM write port and
// sticky overflow flag for pixels beyond the frame size.
module frame_seq_capture #(
  parameter int unsigned PIX_W  = 8,
  parameter int unsigned N_PIX  = 76800,
  parameter int unsigned ADDR_W = 17
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic              vld_i,
  input  logic [PIX_W-1:0]  data_i,
  output logic              full_o,
  output logic              dst_en_o,
  output logic              dst_we_o,
  output logic [ADDR_W-1:0] dst_addr_o,
  output logic [PIX_W-1:0]  dst_data_o,
  output logic              ovf_o
);

  localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(N_PIX);

  logic [ADDR_W-1:0] r_wr_cnt;
  logic              r_wr;
  logic [ADDR_W-1:0] r_addr;
  logic [PIX_W-1:0]  r_data;
  logic              r_ovf;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_wr_cnt <= '0;
      r_wr     <= 1'b0;
      r_addr   <= '0;
      r_data   <= '0;
      r_ovf    <= 1'b0;
    end else begin
      r_wr <= 1'b0;
      if (clr_i) begin
        r_wr_cnt <= '0;
        r_ovf    <= 1'b0;
      end else if (en_i && vld_i) begin
        if (r_wr_cnt < LIMIT) begin
          r_wr     <= 1'b1;
          r_addr   <= r_wr_cnt;
          r_data   <= data_i;
          r_wr_cnt <= r_wr_cnt + ADDR_W'(1);
        end else begin
          r_ovf <= 1'b1;
        end
      end
    end
  end

  assign full_o     = (r_wr_cnt == LIMIT);
  assign dst_en_o   = r_wr;
  assign dst_we_o   = r_wr;
  assign dst_addr_o = r_addr;
  assign dst_data_o = r_data;
  assign ovf_o      = r_ovf;

endmodule

// File: rtl/frame_sequencer.sv
// Frame transfer controller: source RAM -> processing core -> destination RAM.
// Optional stall watchdog enabled by defining FRAME_SEQ_WATCHDOG_EN.
module frame_sequencer
  import frame_seq_pkg::*;
#(
  parameter int unsigned PIX_W  = PIX_W_DEF,
  parameter int unsigned N_PIX  = N_PIX_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
`ifdef FRAME_SEQ_WATCHDOG_EN
  , parameter int unsigned WDOG_CYC = frame_seq_pkg::WDOG_CYC
`endif
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              ovf_o,
  output logic              tmo_o,
  output logic              src_en_o,
  output logic [ADDR_W-1:0] src_addr_o,
  input  logic [PIX_W-1:0]  src_data_i,
  output logic              core_en_o,
  output logic              core_valid_o,
  output logic [PIX_W-1:0]  core_data_o,
  input  logic              core_rdy_i,
  input  logic              core_vld_i,
  input  logic [PIX_W-1:0]  core_data_i,
  output logic              dst_en_o,
  output logic              dst_we_o,
  output logic [ADDR_W-1:0] dst_addr_o,
  output logic [PIX_W-1:0]  dst_data_o
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N_PIX - 1);

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_rd_cnt;
  logic [PIX_W-1:0]  r_hold;
  logic              w_busy;
  logic              w_start;
  logic              w_accept;
  logic              w_full;
  logic              w_wdog_trip;

  assign w_busy   = is_busy(r_state);
  assign w_start  = (r_state == S_IDLE) && start_i;
  assign w_accept = (r_state == S_PUSH) && core_rdy_i;

  always_ff @(posedge clk_i) begin
    if (!rst_i) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    busy_o       = w_busy;
    done_o       = 1'b0;
    src_en_o     = 1'b0;
    core_valid_o = 1'b0;
    unique case (r_state)
      S_IDLE:  if (start_i) w_next = S_RD;
      S_RD: begin
        src_en_o = 1'b1;
        w_next   = S_WAIT;
      end
      S_WAIT:  w_next = S_PUSH;
      S_PUSH: begin
        core_valid_o = 1'b1;
        if (core_rdy_i) w_next = (r_rd_cnt == LAST) ? S_DRAIN : S_RD;
      end
      S_DRAIN: if (w_full) w_next = S_DONE;
      S_DONE: begin
        done_o = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    if (w_wdog_trip) w_next = S_DONE;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_rd_cnt <= '0;
      r_hold   <= '0;
    end else begin
      if (w_start)
        r_rd_cnt <= '0;
      else if (w_accept && (r_rd_cnt != LAST))
        r_rd_cnt <= r_rd_cnt + ADDR_W'(1);
      if (r_state == S_WAIT) r_hold <= src_data_i;
    end
  end

  assign src_addr_o  = r_rd_cnt;
  assign core_en_o   = w_busy;
  assign core_data_o = r_hold;

  frame_seq_capture #(
    .PIX_W  (PIX_W),
    .N_PIX  (N_PIX),
    .ADDR_W (ADDR_W)
  ) u_capture (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clr_i      (w_start),
    .en_i       (w_busy),
    .vld_i      (core_vld_i),
    .data_i     (core_data_i),
    .full_o     (w_full),
    .dst_en_o   (dst_en_o),
    .dst_we_o   (dst_we_o),
    .dst_addr_o (dst_addr_o),
    .dst_data_o (dst_data_o),
    .ovf_o      (ovf_o)
  );

`ifdef FRAME_SEQ_WATCHDOG_EN
  logic [WDOG_W-1:0] r_wdog;
  logic              r_tmo;
  logic              w_waiting;

  // Only PUSH/DRAIN can stall; RD/WAIT always progress, so the count starts at 0 on entering PUSH.
  assign w_waiting   = (r_state == S_PUSH) || (r_state == S_DRAIN);
  assign w_wdog_trip = w_waiting && (r_wdog == WDOG_W'(WDOG_CYC));

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_wdog <= '0;
      r_tmo  <= 1'b0;
    end else begin
      if (w_waiting && !w_accept && !core_vld_i) r_wdog <= r_wdog + WDOG_W'(1);
      else                                       r_wdog <= '0;
      if (w_start)          r_tmo <= 1'b0;
      else if (w_wdog_trip) r_tmo <= 1'b1;
    end
  end

  assign tmo_o = r_tmo;
`else
  assign w_wdog_trip = 1'b0;
  assign tmo_o       = 1'b0;
`endif

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed scoreboard bench for frame_sequencer with a 16-pixel frame and a
// behavioural core that returns input+1 two cycles after each accept.
module tb_frame_sequencer;

  localparam int unsigned PIX_W  = 8;
  localparam int unsigned N_PIX  = 16;
  localparam int unsigned ADDR_W = 5;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              start_i;
  logic              busy_o, done_o, ovf_o, tmo_o;
  logic              src_en_o;
  logic [ADDR_W-1:0] src_addr_o;
  logic [PIX_W-1:0]  src_data_i;
  logic              core_en_o, core_valid_o;
  logic [PIX_W-1:0]  core_data_o;
  logic              core_rdy_i, core_vld_i;
  logic [PIX_W-1:0]  core_data_i;
  logic              dst_en_o, dst_we_o;
  logic [ADDR_W-1:0] dst_addr_o;
  logic [PIX_W-1:0]  dst_data_o;

  always #5 clk_i = ~clk_i;

  frame_sequencer #(
    .PIX_W  (PIX_W),
    .N_PIX  (N_PIX),
    .ADDR_W (ADDR_W)
`ifdef FRAME_SEQ_WATCHDOG_EN
    , .WDOG_CYC (20)
`endif
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .ovf_o        (ovf_o),
    .tmo_o        (tmo_o),
    .src_en_o     (src_en_o),
    .src_addr_o   (src_addr_o),
    .src_data_i   (src_data_i),
    .core_en_o    (core_en_o),
    .core_valid_o (core_valid_o),
    .core_data_o  (core_data_o),
    .core_rdy_i   (core_rdy_i),
    .core_vld_i   (core_vld_i),
    .core_data_i  (core_data_i),
    .dst_en_o     (dst_en_o),
    .dst_we_o     (dst_we_o),
    .dst_addr_o   (dst_addr_o),
    .dst_data_o   (dst_data_o)
  );

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [PIX_W-1:0]  d;
  } wr_t;

  wr_t              exp_q[$];
  logic [PIX_W-1:0] src_mem [N_PIX];
  logic [PIX_W-1:0] dst_mem [N_PIX];

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned done_cnt = 0;
  int unsigned cyc = 0;

  bit          extra_mode = 1'b0;
  bit          stall_mode = 1'b0;
  bit          never_rdy  = 1'b0;
  int unsigned stall_left = 0;
  int unsigned acc_count  = 0;
  int unsigned acc3       = 0;
  int unsigned push3_cyc  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] out_vec();
    return 64'({busy_o, done_o, ovf_o, tmo_o, src_en_o, src_addr_o, core_en_o,
                core_valid_o, core_data_o, dst_en_o, dst_we_o, dst_addr_o, dst_data_o});
  endfunction

  initial forever begin
    @(posedge clk_i);
    cyc++;
  end

  initial forever begin
    @(negedge clk_i);
    if (done_o) done_cnt++;
  end

  // Destination write monitor: pops one expected write per observed RAM write.
  initial begin : monitor
    wr_t e;
    forever begin
      @(negedge clk_i);
      if (dst_en_o || dst_we_o) begin
        if (exp_q.size() == 0) begin
          check("dst_unexpected_wr", 64'({dst_en_o, dst_we_o, dst_addr_o, dst_data_o}), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("dst_wr", 64'({dst_en_o, dst_we_o, dst_addr_o, dst_data_o}),
                64'({2'b11, e.a, e.d}));
        end
        if (dst_addr_o < ADDR_W'(N_PIX)) dst_mem[dst_addr_o] = dst_data_o;
      end
    end
  end

  // Source RAM and core model, both driven half a cycle after each edge.
  initial begin : core_model
    logic             acc;
    logic             p1_v, p2_v, src_pend, inject;
    logic [PIX_W-1:0] p1_d, p2_d;
    logic [ADDR_W-1:0] src_pend_a;
    p1_v = 1'b0; p2_v = 1'b0; p1_d = '0; p2_d = '0;
    src_pend = 1'b0; src_pend_a = '0; inject = 1'b0;
    core_rdy_i = 1'b1; core_vld_i = 1'b0; core_data_i = '0; src_data_i = '0;
    forever begin
      @(negedge clk_i);
      src_data_i = (src_pend && src_pend_a < ADDR_W'(N_PIX)) ? src_mem[src_pend_a] : 8'hEE;
      src_pend   = src_en_o;
      src_pend_a = src_addr_o;

      if (never_rdy)
        core_rdy_i = 1'b0;
      else if (stall_mode && core_valid_o && acc_count == 3 && stall_left > 0) begin
        core_rdy_i = 1'b0;
        stall_left--;
      end else
        core_rdy_i = 1'b1;

      if (stall_mode && core_valid_o && acc_count == 3) begin
        push3_cyc++;
        check("push3_data_hold", 64'(core_data_o), 64'd3);
      end

      acc = core_valid_o && core_rdy_i;
      if (!busy_o) begin
        p1_v = 1'b0; p2_v = 1'b0; inject = 1'b0;
      end
      core_vld_i  = p2_v;
      core_data_i = p2_d;
      p2_v = p1_v;
      p2_d = p1_d;
      if (inject) begin
        p1_v = 1'b1; p1_d = 8'hAA; inject = 1'b0;
      end else begin
        p1_v = acc; p1_d = PIX_W'(core_data_o + 8'd1);
      end
      if (acc) begin
        acc_count++;
        if (core_data_o == 8'd3) acc3++;
        if (extra_mode && acc_count == N_PIX) inject = 1'b1;
      end
    end
  end

  task automatic pulse_start(input string tag);
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    check({tag, "_first_read"}, 64'({busy_o, src_en_o, src_addr_o, ovf_o, tmo_o}),
          64'({1'b1, 1'b1, ADDR_W'(0), 1'b0, 1'b0}));
  endtask

  task automatic wait_done(input string tag, output bit got);
    got = 1'b0;
    for (int k = 0; k < 400 && !got; k++) begin
      @(negedge clk_i);
      if (done_o) got = 1'b1;
    end
    check({tag, "_done_seen"}, 64'(got), 64'd1);
  endtask

  task automatic load_frame();
    for (int i = 0; i < N_PIX; i++) begin
      src_mem[i] = PIX_W'(i);
      dst_mem[i] = 8'h55;
      exp_q.push_back(wr_t'({ADDR_W'(i), PIX_W'(i + 1)}));
    end
  endtask

  task automatic run_frame(input string tag, input bit extra, input bit restart,
                           input int unsigned stall);
    int unsigned d0;
    bit got;
    load_frame();
    extra_mode = extra;
    stall_mode = (stall != 0);
    stall_left = stall;
    acc_count  = 0;
    acc3       = 0;
    push3_cyc  = 0;
    d0         = done_cnt;
    pulse_start(tag);
    if (restart) begin
      got = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
        if (core_valid_o) got = 1'b1;
        else @(negedge clk_i);
      end
      check({tag, "_push_seen"}, 64'(got), 64'd1);
      start_i = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0;
    end
    wait_done(tag, got);
    repeat (6) @(negedge clk_i);
    check({tag, "_done_count"}, 64'(done_cnt - d0), 64'd1);
    check({tag, "_ovf"}, 64'(ovf_o), 64'(extra));
    check({tag, "_writes_left"}, 64'(exp_q.size()), 64'd0);
    for (int i = 0; i < N_PIX; i++)
      check({tag, "_dst_mem"}, 64'(dst_mem[i]), 64'(i + 1));
    if (stall != 0) begin
      check({tag, "_push3_cycles"}, 64'(push3_cyc), 64'(stall + 1));
      check({tag, "_pix3_accepts"}, 64'(acc3), 64'd1);
    end
    extra_mode = 1'b0;
    stall_mode = 1'b0;
  endtask

  initial begin : stimulus
    bit got;
    int unsigned t0;
    rst_i   = 1'b0;
    start_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check("reset_outputs", out_vec(), 64'd0);
    rst_i = 1'b1;
    @(negedge clk_i);

    run_frame("basic", 1'b0, 1'b0, 0);
    run_frame("start_in_push", 1'b0, 1'b1, 0);
    run_frame("stall", 1'b0, 1'b0, 5);
    run_frame("overflow", 1'b1, 1'b0, 0);

    // Reset while reading pixel 7, then a clean frame from address 0.
    load_frame();
    pulse_start("reset_pre");
    got = 1'b0;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk_i);
      if (src_en_o && src_addr_o == ADDR_W'(7)) got = 1'b1;
    end
    check("reset_reach_rd7", 64'(got), 64'd1);
    rst_i = 1'b0;
    @(negedge clk_i);
    check("reset_mid_frame_outputs", out_vec(), 64'd0);
    exp_q.delete();
    rst_i = 1'b1;
    @(negedge clk_i);
    run_frame("after_reset", 1'b0, 1'b0, 0);

`ifdef FRAME_SEQ_WATCHDOG_EN
    never_rdy = 1'b1;
    pulse_start("wdog");
    got = 1'b0;
    t0  = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk_i);
      if (core_valid_o) begin
        got = 1'b1;
        t0  = cyc;
      end
    end
    check("wdog_push_seen", 64'(got), 64'd1);
    got = 1'b0;
    for (int k = 0; k < 100 && !got; k++) begin
      if (done_o) got = 1'b1;
      else @(negedge clk_i);
    end
    check("wdog_done_seen", 64'(got), 64'd1);
    check("wdog_latency", 64'(cyc - t0), 64'd21);
    check("wdog_tmo", 64'(tmo_o), 64'd1);
    never_rdy = 1'b0;
    repeat (4) @(negedge clk_i);
    check("wdog_tmo_sticky", 64'(tmo_o), 64'd1);
    run_frame("wdog_recover", 1'b0, 1'b0, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/frame_sequencer.md
# frame_sequencer

Synthesizable frame transfer controller that replaces the behavioural sequencing around the image-processing core. On a start pulse it reads a full frame of pixels from the source single-port RAM, streams them into the processing core over its accept handshake, and writes every pixel the core emits into the destination single-port RAM. It sits between the two `ram` instances and the `gorev_2` core in the top level.

## Interface
Parameters:
- `PIX_W`, 8, pixel width in bits.
- `N_PIX`, 76800, pixels per frame (320x240).
- `ADDR_W`, 17, RAM address width; must satisfy `2**ADDR_W >= N_PIX`.

Ports:
- `clk_i`  in  1  clock; all logic on rising edge.
- `rst_i`  in  1  synchronous, active-low reset.
- `start_i`  in  1  start a frame; sampled only in IDLE.
- `busy_o`  out  1  high from the cycle after an accepted start until DONE.
- `done_o`  out  1  one-cycle pulse when the frame is complete.
- `ovf_o`  out  1  sticky; core emitted more than `N_PIX` pixels. Cleared by start or reset.
- `src_en_o`  out  1  source RAM enable (read only; `we` is tied low at top).
- `src_addr_o`  out  `ADDR_W`  source read address.
- `src_data_i`  in  `PIX_W`  source read data, valid 1 cycle after `src_en_o`.
- `core_en_o`  out  1  core enable; high while busy.
- `core_valid_o`  out  1  `core_data_o` is valid.
- `core_data_o`  out  `PIX_W`  pixel to core.
- `core_rdy_i`  in  1  core accepts pixel (`veri_al`).
- `core_vld_i`  in  1  core output pixel valid (`veri_gonder`).
- `core_data_i`  in  `PIX_W`  core output pixel.
- `dst_en_o`, `dst_we_o`  out  1  destination RAM enable/write, both asserted for one cycle per captured pixel.
- `dst_addr_o`  out  `ADDR_W`  destination write address.
- `dst_data_o`  out  `PIX_W`  destination write data.

## Operation
- States: IDLE, RD, WAIT, PUSH, DRAIN, DONE.
- IDLE: `start_i`=1 -> clear `rd_cnt`, `wr_cnt`, `ovf_o`; go to RD.
- RD: `src_en_o`=1, `src_addr_o`=`rd_cnt`; go to WAIT.
- WAIT: latch `src_data_i` into the hold register; go to PUSH.
- PUSH: `core_valid_o`=1, `core_data_o`=hold register. On `core_rdy_i`=1: if `rd_cnt`==`N_PIX`-1 go to DRAIN, else increment `rd_cnt` and go to RD. Without ready, the controller stays in PUSH with the data held stable.
- Capture runs in parallel in RD, WAIT, PUSH and DRAIN. Each cycle with `core_vld_i`=1 and `wr_cnt`<`N_PIX` registers a write: `dst_addr_o`=`wr_cnt`, `dst_data_o`=`core_data_i`, then `wr_cnt` increments. With `wr_cnt`==`N_PIX`, the pixel is dropped and `ovf_o` is set.
- DRAIN: go to DONE once `wr_cnt`==`N_PIX`.
- DONE: `done_o`=1 for one cycle; go to IDLE. Captures arriving in DONE or IDLE are ignored and do not set `ovf_o`.
- Counters are `ADDR_W` bits wide and never wrap; the terminal compares use `N_PIX`-1 and `N_PIX`.
- `start_i` outside IDLE is ignored.

## Timing
- Reset (`rst_i`=0 at a clock edge) forces IDLE. All outputs go to 0, both counters and the hold register go to 0, and `ovf_o` is cleared. The same applies mid-frame; no partial writes complete after the reset edge.
- Start-to-first-read latency: 1 cycle (the RD cycle follows the accepting IDLE cycle).
- Feed rate: at most 1 pixel per 3 cycles; each pixel is presented 2 cycles after its read.
- Destination write: registered. RAM control appears the cycle after `core_vld_i` is sampled.
- Simultaneous final accept and final capture: both are honoured in the same cycle; DRAIN is exited on the next cycle.
- `done_o` is asserted exactly 1 cycle after the cycle in which `wr_cnt` reaches `N_PIX`, measured while in DRAIN.

## Configuration
- `FRAME_SEQ_WATCHDOG_EN` defined: a 24-bit idle counter resets on any accept or capture and increments otherwise while busy. When it reaches `WDOG_CYC`, the controller goes to DONE, pulses `done_o`, and sets sticky output `tmo_o`. `tmo_o` is cleared by start or reset.
- Macro undefined: no counter is built and `tmo_o` is tied to 0. The controller can wait indefinitely in PUSH or DRAIN.

## Structure
- Package `frame_seq_pkg`: state enum typedef, `WDOG_CYC` (16,000,000), and the default `N_PIX`/`PIX_W`/`ADDR_W` constants.
- One sub-module, `frame_seq_capture`: `wr_cnt`, the destination RAM write register, and the `ovf_o` logic. It is instantiated once, with enable driven by the main FSM's busy states.

## Test plan
- `N_PIX`=16, core model always ready, echoes input+1 two cycles later. Source 0..15 -> destination holds 1..16, `done_o` pulses once, `ovf_o`=0.
- Ready withheld 5 cycles on pixel 3 -> `core_data_o` stable at 3 for all 6 PUSH cycles, and pixel 3 is accepted exactly once.
- Core emits 17 pixels -> destination holds the first 16, `ovf_o`=1, and the 17th pixel does not alter address 0.
- `rst_i`=0 while `rd_cnt`=7 -> next cycle all outputs are 0 and state is IDLE. A new start then rereads from address 0.
- `start_i` pulsed again during PUSH -> ignored; exactly one `done_o` per frame.
- With `FRAME_SEQ_WATCHDOG_EN` and `WDOG_CYC` set to 20, the core never asserts ready -> `done_o` and `tmo_o`=1 twenty-one cycles after the first PUSH.
